bcd_up_counter_2d: RTL and testbench
====================================

Name: bcd_up_counter_2d

Overview:
- Two-digit BCD up counter (00..99) for the score display path.
- Counts rising edges of a goal/increment input.
- Raises per-digit terminal and carry flags, and latches a win flag when the count reaches a target score.
- Complements the single-digit down counter used for timers: same load/enable style, counts upward with a digit carry chain, and has a small state machine.

Parameters:
TARGET_SCORE, 15, decimal score (0..99) at which win asserts and counting freezes; 0 disables win detection

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
ena  input  1  count enable; low holds the count
loadN  input  1  active-low synchronous load of datain_tens/datain_ones
datain_tens  input  4  BCD tens digit to load
datain_ones  input  4  BCD ones digit to load
inc  input  1  increment request, level or pulse; only its rising edge counts
clear  input  1  synchronous clear to 00, active-high
count_tens  output  4  tens digit
count_ones  output  4  ones digit
tc_ones  output  1  combinational, count_ones == 9
carry  output  1  one-cycle registered pulse on wrap 99 -> 00
win  output  1  registered, high while in state WIN_HOLD

Behaviour:
- Reset (asynchronous, resetN low): count 00, inc_d 0, carry 0, state COUNTING, win 0.
- Edge detect:
  - inc_d registers inc every cycle, regardless of ena or state.
  - rise = inc & ~inc_d.
  - inc held high for N cycles produces exactly one rise.
- Latency: count updates at the same clock edge where rise is first seen, i.e. the first edge sampling inc high.
- Priority per edge: loadN low > clear > (ena & rise & state==COUNTING) > hold.
- Load:
  - Each digit greater than 9 is clamped to 9.
  - State forced to COUNTING, win 0, carry 0.
  - Loading a value >= TARGET_SCORE does not set win.
- Clear: count 00, state COUNTING, win 0, carry 0.
- Increment:
  - ones < 9: ones + 1.
  - ones == 9: ones 0 and tens + 1.
  - tens == 9 and ones == 9: count 00, carry 1 for that cycle.
- carry is 0 on every edge that does not wrap.
- States:
  - COUNTING -> WIN_HOLD when an increment makes the new count equal to TARGET_SCORE (TARGET_SCORE != 0). Win asserts at the same edge the count reaches target.
  - WIN_HOLD: rise is ignored and count holds. Exit to COUNTING only via loadN or clear.
  - Reset from any state goes to COUNTING.
- ena low: count and state hold; carry 0. Edge detection keeps tracking, so inc that rose while disabled and is still high at re-enable does not count.
- Outputs never hold non-BCD digit values.
- Reset mid-operation: immediate return to reset values, no residual carry or win.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined:
  - 99 + 1 stays at 99 (saturate); carry never asserts.
  - tc_ones behaviour unchanged.
- Undefined: wrap 99 -> 00 with a one-cycle carry pulse, as above.

Test Plan:
1. Reset, then ena=1 and 10 separate inc pulses -> count steps 01..09, then tens=1 ones=0; tc_ones high only while count_ones=9.
2. Load 98 (loadN low one cycle), TARGET_SCORE=0, two inc pulses -> 99, then 00 with carry high exactly one cycle. Under BCD_SATURATE_EN: stays 99, carry stays 0.
3. TARGET_SCORE=15, count from 13 with three inc pulses -> 14, then 15 with win=1; the third pulse is ignored (count stays 15, win stays 1); clear -> 00, win 0.
4. loadN low with datain_tens=0xC, datain_ones=0x3 and a simultaneous inc rise -> count 93 (clamped, load wins), no increment that cycle.
5. inc held high 20 cycles with ena=1 -> count +1 only. inc rises while ena=0, then ena goes high with inc still high -> no count.
6. resetN pulsed low mid-count at 47 with carry/win idle -> count 00, win 0, carry 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up counter (00..99) with rising-edge increment and win latch.
// Optional BCD_SATURATE_EN: 99 + 1 saturates at 99 instead of wrapping.
module bcd_up_counter_2d #(
  parameter int TARGET_SCORE = 15
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ena,
  input  logic       loadN,
  input  logic [3:0] datain_tens,
  input  logic [3:0] datain_ones,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       tc_ones,
  output logic       carry,
  output logic       win
);

  typedef enum logic [0:0] {
    COUNTING = 1'b0,
    WIN_HOLD = 1'b1
  } state_e;

  localparam logic [3:0] TGT_T  = 4'(TARGET_SCORE / 10);
  localparam logic [3:0] TGT_O  = 4'(TARGET_SCORE % 10);
  localparam bit         WIN_EN = (TARGET_SCORE != 0);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       carry_q, carry_d;
  logic       inc_q;
  logic       rise;
  logic [3:0] nxt_t, nxt_o;
  logic       nxt_cy;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign rise = inc & ~inc_q;

  // BCD +1 of the current count, with wrap or saturate at 99
  always_comb begin
    nxt_t  = tens_q;
    nxt_o  = ones_q;
    nxt_cy = 1'b0;
    if (ones_q != 4'd9) begin
      nxt_o = ones_q + 4'd1;
    end else if (tens_q != 4'd9) begin
      nxt_o = 4'd0;
      nxt_t = tens_q + 4'd1;
    end else begin
`ifdef BCD_SATURATE_EN
      nxt_t = 4'd9;
      nxt_o = 4'd9;
`else
      nxt_t  = 4'd0;
      nxt_o  = 4'd0;
      nxt_cy = 1'b1;
`endif
    end
  end

  // Next-state: load > clear > enabled increment > hold
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    carry_d = 1'b0;
    if (!loadN) begin
      tens_d  = clamp9(datain_tens);
      ones_d  = clamp9(datain_ones);
      state_d = COUNTING;
    end else if (clear) begin
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      state_d = COUNTING;
    end else if (ena && rise && state_q == COUNTING) begin
      tens_d  = nxt_t;
      ones_d  = nxt_o;
      carry_d = nxt_cy;
      if (WIN_EN && nxt_t == TGT_T && nxt_o == TGT_O)
        state_d = WIN_HOLD;
    end
  end

  // Count, state, carry and increment-history registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= COUNTING;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      carry_q <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      carry_q <= carry_d;
      inc_q   <= inc;
    end
  end

  assign count_tens = tens_q;
  assign count_ones = ones_q;
  assign tc_ones    = (ones_q == 4'd9);
  assign carry      = carry_q;
  assign win        = (state_q == WIN_HOLD);

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Bench for bcd_up_counter_2d: two instances (target 15 and target 0)
// driven in lockstep and compared against an integer score model.
module tb_bcd_up_counter_2d;

  logic       clk = 1'b0;
  logic       resetN, ena, loadN, inc, clear;
  logic [3:0] dt, dn;
  logic [3:0] ct [2];
  logic [3:0] co [2];
  logic       tc [2];
  logic       cy [2];
  logic       wn [2];

  int vectors = 0;
  int miscompares = 0;

  int m_cnt [2];
  bit m_win [2];
  bit m_cy  [2];
  bit m_prev;
  int tgt   [2] = '{15, 0};

  always #5 clk = ~clk;

  bcd_up_counter_2d #(.TARGET_SCORE(15)) u_t15 (
    .clk(clk), .resetN(resetN), .ena(ena), .loadN(loadN),
    .datain_tens(dt), .datain_ones(dn), .inc(inc), .clear(clear),
    .count_tens(ct[0]), .count_ones(co[0]), .tc_ones(tc[0]),
    .carry(cy[0]), .win(wn[0])
  );

  bcd_up_counter_2d #(.TARGET_SCORE(0)) u_t0 (
    .clk(clk), .resetN(resetN), .ena(ena), .loadN(loadN),
    .datain_tens(dt), .datain_ones(dn), .inc(inc), .clear(clear),
    .count_tens(ct[1]), .count_ones(co[1]), .tc_ones(tc[1]),
    .carry(cy[1]), .win(wn[1])
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_win[k] = 0;
      m_cy[k]  = 0;
    end
    m_prev = 0;
  endtask

  task automatic model_edge();
    bit rise;
    int t, o;
    rise = inc && !m_prev;
    m_prev = inc;
    t = (int'(dt) > 9) ? 9 : int'(dt);
    o = (int'(dn) > 9) ? 9 : int'(dn);
    for (int k = 0; k < 2; k++) begin
      m_cy[k] = 0;
      if (!loadN) begin
        m_cnt[k] = t * 10 + o;
        m_win[k] = 0;
      end else if (clear) begin
        m_cnt[k] = 0;
        m_win[k] = 0;
      end else if (ena && rise && !m_win[k]) begin
        if (m_cnt[k] == 99) begin
`ifdef BCD_SATURATE_EN
          m_cnt[k] = 99;
`else
          m_cnt[k] = 0;
          m_cy[k]  = 1;
`endif
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (tgt[k] != 0 && m_cnt[k] == tgt[k])
          m_win[k] = 1;
      end
    end
  endtask

  task automatic chk1(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      e = {4'(m_cnt[k] / 10), 4'(m_cnt[k] % 10)};
      chk1($sformatf("%s[%0d].count", tag, k), {ct[k], co[k]}, e);
      chk1($sformatf("%s[%0d].tc_ones", tag, k), {7'd0, tc[k]},
           {7'd0, (m_cnt[k] % 10) == 9});
      chk1($sformatf("%s[%0d].carry", tag, k), {7'd0, cy[k]},
           {7'd0, m_cy[k]});
      chk1($sformatf("%s[%0d].win", tag, k), {7'd0, wn[k]},
           {7'd0, m_win[k]});
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic pulse(string tag);
    inc = 1'b1;
    step(tag);
    inc = 1'b0;
    step(tag);
  endtask

  task automatic load(logic [3:0] t, logic [3:0] o);
    loadN = 1'b0;
    dt = t;
    dn = o;
    step("load");
    loadN = 1'b1;
  endtask

  task automatic async_reset(string tag);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    check(tag);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    ena    = 1'b0;
    loadN  = 1'b1;
    inc    = 1'b0;
    clear  = 1'b0;
    dt     = 4'd0;
    dn     = 4'd0;
    model_reset();
    #12;
    check("reset");
    resetN = 1'b1;

    ena = 1'b1;
    repeat (10) pulse("t1_count");

    load(4'd9, 4'd8);
    pulse("t2_wrap");
    pulse("t2_wrap");

    load(4'd1, 4'd3);
    repeat (3) pulse("t3_win");
    clear = 1'b1;
    step("t3_clear");
    clear = 1'b0;

    loadN = 1'b0;
    dt = 4'hC;
    dn = 4'd3;
    inc = 1'b1;
    step("t4_clamp");
    loadN = 1'b1;
    inc = 1'b0;
    step("t4_hold");

    inc = 1'b1;
    repeat (20) step("t5_level");
    inc = 1'b0;
    step("t5_level");
    ena = 1'b0;
    inc = 1'b1;
    repeat (2) step("t5_dis");
    ena = 1'b1;
    repeat (3) step("t5_reen");
    inc = 1'b0;
    step("t5_reen");

    load(4'd4, 4'd6);
    pulse("t6_pre");
    async_reset("t6_reset");
    step("t6_post");

    repeat (400) begin
      loadN = ($urandom % 16) != 0;
      dt    = 4'($urandom);
      dn    = 4'($urandom);
      clear = ($urandom % 32) == 0;
      ena   = ($urandom % 4) != 0;
      inc   = 1'($urandom);
      step("rand");
      if (($urandom % 100) == 0) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
